bomb_keypad: RTL and testbench
==============================

# bomb_keypad

Input conditioning stage directly upstream of the bomb controller's password-entry logic. Takes the three raw, bouncing, active-low board push-buttons, synchronises and debounces each one, and emits a single-cycle press pulse per physical press. Simultaneous presses are serialised so the controller never sees more than one button pulse in a cycle. Outputs drive the controller's `btn0`/`btn1`/`btn2` inputs directly.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period; used only when `BOMB_KEYPAD_AUTOREPEAT_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `async_reset`  in  1  reset: **one clock; reset is asynchronous and active-high.**
- `key_n`  in  3  raw push-buttons, active-low, asynchronous to `clk`.
- `btn_pulse`  out  3  one-hot or zero; bit i high for exactly one cycle per accepted press of key i; registered.
- `key_held`  out  3  debounced level, 1 = pressed; registered.

## Operation

- Per key, a 2-flop synchroniser on `~key_n[i]`. Reset value of the synchroniser flops is 0 (released).
- Per key, a 4-state FSM with its own counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - RELEASED: if the synced level is 1, go to PRESS_WAIT with count = 1.
  - PRESS_WAIT: if synced is 1, increment the count. When the count reaches `DEBOUNCE_CYCLES`, go to PRESSED, set `key_held[i]`, and set `pending[i]`. If synced is 0, return to RELEASED and clear the count.
  - PRESSED: if synced is 0, go to RELEASE_WAIT with count = 1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. On reaching `DEBOUNCE_CYCLES`, go to RELEASED and clear `key_held[i]`; no pulse is generated. A glitch back to 1 returns the FSM to PRESSED.
- Serialiser: a 3-bit `pending` register.
  - Each cycle, the lowest-index set bit is moved to `btn_pulse` and cleared from `pending`. All other `btn_pulse` bits are 0.
  - A new set and a clear of the same bit in one cycle: the set wins.
  - A second press of a key while its `pending` bit is still set is merged (one pulse).
- Reset (asynchronous, any time, including mid-debounce): all FSMs go to RELEASED, counters to 0, `pending` = 0, `btn_pulse` = 0, `key_held` = 0. After reset release, a key already held down is treated as a new press and must still complete the full debounce.

## Timing

- A raw level change is first captured at clock edge 1. The synced level is valid after edge 2.
- `key_held` rises after edge `DEBOUNCE_CYCLES+2`.
- `btn_pulse[i]` is high for the single cycle after edge `DEBOUNCE_CYCLES+3`, provided no lower-index key is pending.
- Each pending lower-index key delays the pulse by one further cycle. Worst case is 2 extra cycles.
- Bounce shorter than `DEBOUNCE_CYCLES` samples never changes `key_held` and never produces a pulse.
- Counters saturate at `DEBOUNCE_CYCLES` and never wrap.
- Back-to-back presses of different keys produce pulses on consecutive cycles at most; there is no throughput limit beyond that.

## Configuration

- Macro: `BOMB_KEYPAD_AUTOREPEAT_EN`.
- Defined:
  - In PRESSED, a repeat counter runs. Each time it reaches `REPEAT_CYCLES`, `pending[i]` is set and the counter restarts.
  - The counter clears on entry to PRESSED and in every other state.
- Undefined: no repeat counter exists; exactly one pulse per press regardless of hold time.

## Test plan

Use `DEBOUNCE_CYCLES=4` and `REPEAT_CYCLES=10` in simulation.

1. Reset asserted mid-PRESS_WAIT (key 1 held 3 cycles), then released with the key still held → `btn_pulse=000` and `key_held=000` during reset; `key_held[1]` rises 6 edges after reset release; one pulse `010` one cycle later.
2. Clean press of key 0 held 20 cycles (macro off) → `key_held[0]` rises after edge 6; `btn_pulse=001` exactly one cycle, after edge 7; no further pulses; release gives no pulse and `key_held[0]` falls 6 edges after release.
3. Key 2 bouncing 1/0 every 2 cycles for 30 cycles, then released → `key_held` stays 000; no pulse.
4. Keys 0, 1 and 2 pressed on the same raw cycle → pulses `001`, `010`, `100` on three consecutive cycles; never two bits high together.
5. Key 1 press, release, press, each phase stable for 6 cycles → exactly two `010` pulses.
6. Macro defined, key 0 held 40 cycles → first pulse after edge 7, then repeat pulses every 10 cycles (3 repeats); none after release.

Source files
------------

// File: rtl/bomb_keypad.sv
// bomb_keypad: synchronises and debounces three active-low push-buttons, then
// serialises accepted presses into single-cycle, one-hot btn_pulse outputs.
// Optional auto-repeat while a key stays pressed: define BOMB_KEYPAD_AUTOREPEAT_EN.
module bomb_keypad #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       async_reset,
   input  logic [2:0] key_n,
   output logic [2:0] btn_pulse,
   output logic [2:0] key_held
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("bomb_keypad: DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("bomb_keypad: REPEAT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } state_t;

   logic [2:0]    sync1_q, sync2_q;
   state_t        state_q [3];
   state_t        state_d [3];
   logic [CW-1:0] cnt_q   [3];
   logic [CW-1:0] cnt_d   [3];
   logic [2:0]    press_set;
   logic [2:0]    rep_set;
   logic [2:0]    grant;
   logic [2:0]    pending_q, pending_d;
   logic [2:0]    btn_pulse_q;
   logic [2:0]    key_held_q, key_held_d;

   // Two-flop synchroniser on the inverted (active-high) key levels.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ~key_n;
         sync2_q <= sync1_q;
      end
   end

   // Per-key debounce state and counter registers.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= S_RELEASED;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next-state: accept a level change only after DEBOUNCE_CYCLES matching samples.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_RELEASED: begin
               if (sync2_q[i]) begin
                  state_d[i] = S_PRESS_WAIT;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            S_PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_RELEASED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] >= DEB_MAX - CNT_ONE) begin
                  state_d[i] = S_PRESSED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i]   = cnt_q[i] + CNT_ONE;
               end
            end
            S_PRESSED: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_RELEASE_WAIT;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            S_RELEASE_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = S_PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] >= DEB_MAX - CNT_ONE) begin
                  state_d[i] = S_RELEASED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i]   = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = S_RELEASED;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Outputs: press events, held level and lowest-index-first serialisation.
   always_comb begin
      press_set  = '0;
      key_held_d = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         press_set[i]  = (state_q[i] == S_PRESS_WAIT) && (state_d[i] == S_PRESSED);
         key_held_d[i] = (state_d[i] == S_PRESSED) || (state_d[i] == S_RELEASE_WAIT);
      end
      grant     = pending_q & (~pending_q + 3'd1);
      // A set arriving in the same cycle as the grant of that bit survives.
      pending_d = (pending_q & ~grant) | press_set | rep_set;
   end

`ifdef BOMB_KEYPAD_AUTOREPEAT_EN
   localparam int unsigned    RCW     = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RCW-1:0] REP_MAX = RCW'(REPEAT_CYCLES);
   localparam logic [RCW-1:0] REP_ONE = RCW'(1);

   logic [RCW-1:0] rep_q [3];
   logic [RCW-1:0] rep_d [3];

   // Repeat timer runs only while a key stays in PRESSED; cleared on entry.
   always_comb begin
      rep_set = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         rep_d[i] = '0;
         if ((state_q[i] == S_PRESSED) && (state_d[i] == S_PRESSED)) begin
            if (rep_q[i] >= REP_MAX - REP_ONE) begin
               rep_set[i] = 1'b1;
            end else begin
               rep_d[i] = rep_q[i] + REP_ONE;
            end
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         for (int unsigned i = 0; i < 3; i++) rep_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) rep_q[i] <= rep_d[i];
      end
   end
`else
   assign rep_set = '0;
`endif

   // Serialiser and output registers.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         pending_q   <= '0;
         btn_pulse_q <= '0;
         key_held_q  <= '0;
      end else begin
         pending_q   <= pending_d;
         btn_pulse_q <= grant;
         key_held_q  <= key_held_d;
      end
   end

   assign btn_pulse = btn_pulse_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_bomb_keypad.sv
// Bench for bomb_keypad: directed scenarios plus random key activity, every
// cycle checked against a run-length debounce / pending-set reference model.
// Build with BOMB_KEYPAD_AUTOREPEAT_EN defined to cover auto-repeat.
module tb_bomb_keypad;

   localparam int unsigned DEB = 4;
   localparam int unsigned REP = 10;

   logic       clk = 1'b0;
   logic       async_reset;
   logic [2:0] key_n;
   logic [2:0] btn_pulse;
   logic [2:0] key_held;

   bomb_keypad #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .key_n       (key_n),
      .btn_pulse   (btn_pulse),
      .key_held    (key_held)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned pulse_cnt [3];

   // reference model state
   logic [2:0]  m_s1, m_s2, m_acc, m_pend, m_pulse;
   int unsigned m_run [3];
   int unsigned m_rep [3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_pend = '0; m_pulse = '0;
      for (int i = 0; i < 3; i++) begin
         m_run[i] = 0;
         m_rep[i] = 0;
      end
   endtask

   // One clock edge: accepted level flips after DEB consecutive differing samples;
   // accepted presses (and repeats) join a pending set drained lowest bit first.
   task automatic model_step(input logic [2:0] kn);
      logic [2:0] sets;
      logic       in_b;
      bit         stable_before;
      bit         found;
      sets = '0;
      for (int i = 0; i < 3; i++) begin
         in_b          = m_s2[i];
         stable_before = m_acc[i] && (m_run[i] == 0);
         if (in_b != m_acc[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_acc[i] = in_b;
               m_run[i] = 0;
               if (in_b) sets[i] = 1'b1;
            end
         end else begin
            m_run[i] = 0;
         end
`ifdef BOMB_KEYPAD_AUTOREPEAT_EN
         if (stable_before && m_acc[i] && (m_run[i] == 0)) begin
            m_rep[i]++;
            if (m_rep[i] == REP) begin
               sets[i]  = 1'b1;
               m_rep[i] = 0;
            end
         end else begin
            m_rep[i] = 0;
         end
`else
         if (stable_before) m_rep[i] = 0;
`endif
      end
      m_pulse = '0;
      found   = 0;
      for (int i = 0; i < 3; i++) begin
         if (!found && m_pend[i]) begin
            m_pulse[i] = 1'b1;
            found      = 1;
         end
      end
      m_pend = (m_pend & ~m_pulse) | sets;
      m_s2   = m_s1;
      m_s1   = ~kn;
   endtask

   task automatic tick();
      @(posedge clk);
      if (async_reset) model_reset();
      else             model_step(key_n);
      #1;
      check_eq("btn_pulse", {29'd0, btn_pulse}, {29'd0, m_pulse});
      check_eq("key_held", {29'd0, key_held}, {29'd0, m_acc});
      check_eq("pulse_onehot0", {31'd0, ($countones(btn_pulse) <= 1)}, 32'd1);
      for (int i = 0; i < 3; i++) pulse_cnt[i] += btn_pulse[i];
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 3; i++) pulse_cnt[i] = 0;
   endtask

   task automatic expect_pulses(input string tag, input int unsigned e0, input int unsigned e1,
                                input int unsigned e2);
      check_eq({tag, "_k0_pulses"}, pulse_cnt[0], e0);
      check_eq({tag, "_k1_pulses"}, pulse_cnt[1], e1);
      check_eq({tag, "_k2_pulses"}, pulse_cnt[2], e2);
   endtask

   initial begin
      async_reset = 1'b1;
      key_n       = '1;
      model_reset();
      clear_counts();
      run(2);
      async_reset = 1'b0;
      run(2);

      // 1: reset arrives mid-debounce of key 1, key stays held through release
      key_n = 3'b101;
      run(4);
      async_reset = 1'b1;
      #1;
      check_eq("rst_async_pulse", {29'd0, btn_pulse}, 32'd0);
      check_eq("rst_async_held", {29'd0, key_held}, 32'd0);
      run(3);
      clear_counts();
      async_reset = 1'b0;
      run(5);
      check_eq("s1_held_before_edge6", {29'd0, key_held}, 32'd0);
      run(1);
      check_eq("s1_held_at_edge6", {29'd0, key_held}, 32'h2);
      run(1);
      check_eq("s1_pulse_at_edge7", {29'd0, btn_pulse}, 32'h2);
      run(3);
      key_n = 3'b111;
      run(10);
      expect_pulses("s1", 0, 1, 0);

      // 2: clean 20-cycle press of key 0
      clear_counts();
      key_n = 3'b110;
      run(20);
      key_n = 3'b111;
      run(10);
`ifdef BOMB_KEYPAD_AUTOREPEAT_EN
      expect_pulses("s2", 2, 0, 0);
`else
      expect_pulses("s2", 1, 0, 0);
`endif

      // 3: key 2 bouncing every 2 cycles never qualifies
      clear_counts();
      for (int c = 0; c < 30; c++) begin
         key_n = ((c % 4) < 2) ? 3'b011 : 3'b111;
         tick();
      end
      key_n = 3'b111;
      run(10);
      expect_pulses("s3", 0, 0, 0);

      // 4: all three keys pressed on the same raw cycle
      clear_counts();
      key_n = 3'b000;
      run(10);
      key_n = 3'b111;
      run(10);
      expect_pulses("s4", 1, 1, 1);

      // 5: key 1 press / release / press, 6 cycles each
      clear_counts();
      key_n = 3'b101; run(6);
      key_n = 3'b111; run(6);
      key_n = 3'b101; run(6);
      key_n = 3'b111; run(10);
      expect_pulses("s5", 0, 2, 0);

`ifdef BOMB_KEYPAD_AUTOREPEAT_EN
      // 6: long hold of key 0 with auto-repeat
      clear_counts();
      key_n = 3'b110;
      run(40);
      key_n = 3'b111;
      run(15);
      expect_pulses("s6", 4, 0, 0);
`endif

      // random key activity with random hold lengths
      for (int s = 0; s < 60; s++) begin
         key_n = 3'($urandom);
         run(int'($urandom_range(1, 12)));
      end
      key_n = 3'b111;
      run(15);

      // random reset assertion in the middle of activity
      key_n = 3'($urandom);
      run(3);
      async_reset = 1'b1;
      run(2);
      async_reset = 1'b0;
      run(12);
      key_n = 3'b111;
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
